// File: rtl/stream_write_buffer.sv
// stream_write_buffer: ping-pong staging buffer; captures in0 into one memory half while draining the other to the databus.
// Latency: first capture write delay0+1 cycles after run; first drain read 1 cycle after run, first beat 1 cycle later.
// Backpressure: databus_ready_0 low holds the head beat; reads stall once FIFO entries plus reads in flight reach 2.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run, running        start pulse (restarts both sides), running is ignored
//   done                drain complete (high at reset and when idle)
//   in0                 datapath value captured on port 0
//   databus_*_0         write-beat interface (valid/ready/addr/wdata/wstrb/len/last)
//   ext_dp_*_0_port_0   dual-port memory port 0, capture (write) side
//   ext_dp_*_0_port_1   dual-port memory port 1, drain (read) side
//   ext_addr, int_addr, incr, size, length, delay0, pingPong   run configuration
module stream_write_buffer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int AXI_ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  running,
  output logic                  done,
  input  logic [DATA_W-1:0]     in0,
  output logic                  databus_valid_0,
  input  logic                  databus_ready_0,
  output logic [AXI_ADDR_W-1:0] databus_addr_0,
  input  logic [DATA_W-1:0]     databus_rdata_0,
  output logic [DATA_W-1:0]     databus_wdata_0,
  output logic [DATA_W/8-1:0]   databus_wstrb_0,
  output logic [7:0]            databus_len_0,
  input  logic                  databus_last_0,
  output logic [ADDR_W-1:0]     ext_dp_addr_0_port_0,
  output logic [DATA_W-1:0]     ext_dp_out_0_port_0,
  input  logic [DATA_W-1:0]     ext_dp_in_0_port_0,
  output logic                  ext_dp_enable_0_port_0,
  output logic                  ext_dp_write_0_port_0,
  output logic [ADDR_W-1:0]     ext_dp_addr_0_port_1,
  output logic [DATA_W-1:0]     ext_dp_out_0_port_1,
  input  logic [DATA_W-1:0]     ext_dp_in_0_port_1,
  output logic                  ext_dp_enable_0_port_1,
  output logic                  ext_dp_write_0_port_1,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [ADDR_W-1:0]     int_addr,
  input  logic [ADDR_W-1:0]     incr,
  input  logic [31:0]           size,
  input  logic [7:0]            length,
  input  logic [31:0]           delay0,
  input  logic                  pingPong
);

  // Inputs that exist only for interface uniformity with the other units.
  logic unused_inputs;
  assign unused_inputs = running ^ (^databus_rdata_0) ^ (^ext_dp_in_0_port_0);

  // Run-level state
  logic                  pp_q, pp_d;
  logic                  done_q, done_d;
  logic [AXI_ADDR_W-1:0] axi_addr_q, axi_addr_d;
  logic [7:0]            len_q, len_d;

  // Capture side
  logic [31:0]           delay_q, delay_d;
  logic [31:0]           cap_rem_q, cap_rem_d;
  logic [ADDR_W-1:0]     cap_addr_q, cap_addr_d;

  // Drain side
  logic [31:0]           rd_rem_q, rd_rem_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_W-1:0]     fifo_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  // Datapath decode
  logic                  cap_en;
  logic                  fifo_empty;
  logic                  bus_vld;
  logic [DATA_W-1:0]     bus_head;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic                  fifo_we;
  logic                  fin;
  logic [1:0]            occ;
  logic                  rd_en;

  assign cap_en     = (delay_q == 32'd0) && (cap_rem_q != 32'd0);
  assign fifo_empty = (cnt_q == 2'd0);

  // The word returning from memory this cycle is already visible as the
  // head when the FIFO is empty; this is what gives a beat one cycle after
  // the first read. If it is not accepted it is written into the FIFO, so
  // the head value stays the same next cycle.
  assign bus_vld  = !done_q && (!fifo_empty || inflight_q);
  assign bus_head = fifo_empty ? ext_dp_in_0_port_1 : fifo_q[rd_ptr_q];
  assign pop      = bus_vld && databus_ready_0;
  assign pop_fifo = pop && !fifo_empty;
  assign push     = inflight_q && !(pop && fifo_empty);
  assign fin      = pop && databus_last_0;
  assign fifo_we  = push && !fin && !run;

  // Reads in flight reserve a FIFO slot, so two slots can never overflow.
  assign occ   = cnt_q + {1'b0, inflight_q};
  assign rd_en = !done_q && !fin && (rd_rem_q != 32'd0) && (occ < 2'd2);

  // Port 0: capture writes into the half selected by pp.
  assign ext_dp_enable_0_port_0 = cap_en;
  assign ext_dp_write_0_port_0  = cap_en;
  assign ext_dp_addr_0_port_0   = cap_en ?
      {pp_q ^ cap_addr_q[ADDR_W-1], cap_addr_q[ADDR_W-2:0]} : '0;
  assign ext_dp_out_0_port_0    = cap_en ? in0 : '0;

  // Port 1: drain reads from the opposite half, filled by the previous run.
  assign ext_dp_enable_0_port_1 = rd_en;
  assign ext_dp_write_0_port_1  = 1'b0;
  assign ext_dp_addr_0_port_1   = rd_en ?
      {~pp_q ^ rd_addr_q[ADDR_W-1], rd_addr_q[ADDR_W-2:0]} : '0;
  assign ext_dp_out_0_port_1    = '0;

  // Databus
  assign databus_valid_0 = bus_vld;
  assign databus_wdata_0 = bus_vld ? bus_head : '0;
  assign databus_wstrb_0 = '1;
  assign databus_addr_0  = axi_addr_q;
  assign databus_len_0   = len_q;
  assign done            = done_q;

  always_comb begin
    pp_d       = pp_q;
    done_d     = done_q;
    axi_addr_d = axi_addr_q;
    len_d      = len_q;
    delay_d    = delay_q;
    cap_rem_d  = cap_rem_q;
    cap_addr_d = cap_addr_q;
    rd_rem_d   = rd_rem_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = rd_en;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    // Capture: count down the start delay, then one write per cycle.
    if (delay_q != 32'd0) begin
      delay_d = delay_q - 32'd1;
    end else if (cap_rem_q != 32'd0) begin
      cap_rem_d  = cap_rem_q - 32'd1;
      cap_addr_d = cap_addr_q + incr;
    end

    // Drain: linear read addresses.
    if (rd_en) begin
      rd_rem_d  = rd_rem_q - 32'd1;
      rd_addr_d = rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end

    // FIFO bookkeeping (a bypassed beat never touches storage).
    if (pop_fifo) rd_ptr_d = ~rd_ptr_q;
    if (push)     wr_ptr_d = ~wr_ptr_q;
    case ({push, pop_fifo})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    // Final handshake: drop anything still buffered or returning.
    if (fin) begin
      done_d     = 1'b1;
      rd_rem_d   = 32'd0;
      inflight_d = 1'b0;
      cnt_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end

    // A new run overrides everything, including a drain in progress.
    if (run) begin
      pp_d       = pingPong ? ~pp_q : 1'b0;
      axi_addr_d = ext_addr;
      len_d      = length;
      done_d     = (size == 32'd0);
      delay_d    = delay0;
      cap_rem_d  = size;
      cap_addr_d = int_addr;
      rd_rem_d   = size;
      rd_addr_d  = '0;
      inflight_d = 1'b0;
      cnt_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q       <= 1'b0;
      done_q     <= 1'b1;
      axi_addr_q <= '0;
      len_q      <= '0;
      delay_q    <= '0;
      cap_rem_q  <= '0;
      cap_addr_q <= '0;
      rd_rem_q   <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      pp_q       <= pp_d;
      done_q     <= done_d;
      axi_addr_q <= axi_addr_d;
      len_q      <= len_d;
      delay_q    <= delay_d;
      cap_rem_q  <= cap_rem_d;
      cap_addr_q <= cap_addr_d;
      rd_rem_q   <= rd_rem_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (fifo_we) fifo_q[wr_ptr_q] <= ext_dp_in_0_port_1;
    end
  end

endmodule

// File: tb/tb_stream_write_buffer.sv
// Directed bench for stream_write_buffer with a 1-cycle-latency dual-port memory model.
module tb_stream_write_buffer;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 12;
  localparam int AXI_ADDR_W = 64;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  run = 1'b0;
  logic                  running = 1'b0;
  logic                  done;
  logic [DATA_W-1:0]     in0 = '0;
  logic                  databus_valid_0;
  logic                  databus_ready_0 = 1'b0;
  logic [AXI_ADDR_W-1:0] databus_addr_0;
  logic [DATA_W-1:0]     databus_rdata_0 = '0;
  logic [DATA_W-1:0]     databus_wdata_0;
  logic [DATA_W/8-1:0]   databus_wstrb_0;
  logic [7:0]            databus_len_0;
  logic                  databus_last_0 = 1'b0;
  logic [ADDR_W-1:0]     p0_addr;
  logic [DATA_W-1:0]     p0_out;
  logic [DATA_W-1:0]     p0_in = '0;
  logic                  p0_en, p0_we;
  logic [ADDR_W-1:0]     p1_addr;
  logic [DATA_W-1:0]     p1_out;
  logic [DATA_W-1:0]     p1_in = '0;
  logic                  p1_en, p1_we;
  logic [AXI_ADDR_W-1:0] ext_addr = '0;
  logic [ADDR_W-1:0]     int_addr = '0;
  logic [ADDR_W-1:0]     incr = '0;
  logic [31:0]           size = '0;
  logic [7:0]            length = '0;
  logic [31:0]           delay0 = '0;
  logic                  pingPong = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int beats   = 0;
  int cur_size = 0;

  logic [DATA_W-1:0] mem [4096];

  stream_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AXI_ADDR_W(AXI_ADDR_W)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done), .in0(in0),
    .databus_valid_0(databus_valid_0), .databus_ready_0(databus_ready_0),
    .databus_addr_0(databus_addr_0), .databus_rdata_0(databus_rdata_0),
    .databus_wdata_0(databus_wdata_0), .databus_wstrb_0(databus_wstrb_0),
    .databus_len_0(databus_len_0), .databus_last_0(databus_last_0),
    .ext_dp_addr_0_port_0(p0_addr), .ext_dp_out_0_port_0(p0_out), .ext_dp_in_0_port_0(p0_in),
    .ext_dp_enable_0_port_0(p0_en), .ext_dp_write_0_port_0(p0_we),
    .ext_dp_addr_0_port_1(p1_addr), .ext_dp_out_0_port_1(p1_out), .ext_dp_in_0_port_1(p1_in),
    .ext_dp_enable_0_port_1(p1_en), .ext_dp_write_0_port_1(p1_we),
    .ext_addr(ext_addr), .int_addr(int_addr), .incr(incr), .size(size),
    .length(length), .delay0(delay0), .pingPong(pingPong)
  );

  always #5 clk = ~clk;

  // External dual-port memory, one cycle read latency.
  always @(posedge clk) begin
    if (p0_en && p0_we) mem[p0_addr] <= p0_out;
    if (p1_en) p1_in <= mem[p1_addr];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] ea, input logic [11:0] ia, input logic [11:0] inc,
                           input logic [31:0] sz, input logic [7:0] ln, input logic [31:0] dly,
                           input logic ppen);
    ext_addr = ea; int_addr = ia; incr = inc; size = sz; length = ln;
    delay0 = dly; pingPong = ppen;
    databus_ready_0 = 1'b0; databus_last_0 = 1'b0;
    beats = 0; cur_size = int'(sz);
    run = 1'b1;
  endtask

  // Advance one cycle, apply this cycle's inputs, let them settle.
  task automatic cyc(input logic [31:0] din, input logic rdy);
    step();
    run = 1'b0;
    in0 = din;
    databus_ready_0 = rdy;
    databus_last_0 = (beats == cur_size - 1);
    #1;
  endtask

  task automatic acct();
    if (databus_valid_0 && databus_ready_0) beats++;
  endtask

  logic [31:0] exp_b [8];
  logic [11:0] cap_c [8];
  logic        pat   [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    exp_b = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd0, 32'd0, 32'd0, 32'd0};
    cap_c = '{12'h7FE, 12'h801, 12'h804, 12'h807, 12'h80A, 12'h80D, 12'h810, 12'h813};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---------------- reset values ----------------
    #2 rst = 1'b1;
    #10;
    check("rst_done",  64'(done), 64'd1);
    check("rst_valid", 64'(databus_valid_0), 64'd0);
    check("rst_wstrb", 64'(databus_wstrb_0), 64'hF);
    check("rst_addr",  64'(databus_addr_0), 64'd0);
    check("rst_wdata", 64'(databus_wdata_0), 64'd0);
    check("rst_len",   64'(databus_len_0), 64'd0);
    check("rst_p0en",  64'(p0_en), 64'd0);
    check("rst_p1en",  64'(p1_en), 64'd0);
    @(negedge clk) rst = 1'b0;
    step();

    // ---------------- run A: capture 10..13 into upper half ----------------
    start_run(64'h1000, 12'h000, 12'h001, 32'd4, 8'd3, 32'd2, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      cyc(32'(10 + c - 3), 1'b1);
      if (c == 1) begin
        check("A_done_fall", 64'(done), 64'd0);
        check("A_valid_c1",  64'(databus_valid_0), 64'd0);
        check("A_p1en_c1",   64'(p1_en), 64'd1);
        check("A_p1addr_c1", 64'(p1_addr), 64'h000);
        check("A_bus_addr",  64'(databus_addr_0), 64'h1000);
        check("A_len",       64'(databus_len_0), 64'd3);
      end
      check("A_p0en", 64'(p0_en), 64'((c >= 3) && (c <= 6)));
      if (c >= 3 && c <= 6) begin
        check("A_p0addr", 64'(p0_addr), 64'(12'h800 + 12'(c - 3)));
        check("A_p0out",  64'(p0_out), 64'(10 + c - 3));
      end
      check("A_valid", 64'(databus_valid_0), 64'((c >= 2) && (c <= 5)));
      if (c == 6) check("A_done", 64'(done), 64'd1);
      acct();
    end

    // ---------------- run B: drain 10..13,0.. with ready high ----------------
    start_run(64'h2000, 12'h000, 12'h001, 32'd8, 8'd7, 32'd0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      cyc(32'(32'h100 + c - 1), 1'b1);
      if (c == 1) check("B_p1addr_c1", 64'(p1_addr), 64'h800);
      check("B_p0en", 64'(p0_en), 64'((c >= 1) && (c <= 8)));
      if (c <= 8) check("B_p0addr", 64'(p0_addr), 64'(c - 1));
      check("B_valid", 64'(databus_valid_0), 64'((c >= 2) && (c <= 9)));
      if (c >= 2 && c <= 9) check("B_wdata", 64'(databus_wdata_0), 64'(exp_b[c-2]));
      if (c == 9) check("B_done_c9", 64'(done), 64'd0);
      if (c == 10) begin
        check("B_done", 64'(done), 64'd1);
        check("B_beats", 64'(beats), 64'd8);
      end
      acct();
    end

    // ---------------- run C: ready toggling, wrapping capture addresses ----------------
    start_run(64'h3000, 12'hFFE, 12'h003, 32'd8, 8'd7, 32'd1, 1'b1);
    for (int c = 1; c <= 60; c++) begin
      cyc(32'(32'h200 + c - 2), pat[(c - 1) % 4]);
      if (c <= 10) check("C_p0en", 64'(p0_en), 64'((c >= 2) && (c <= 9)));
      if (c >= 2 && c <= 9) begin
        check("C_p0addr", 64'(p0_addr), 64'(cap_c[c-2]));
        check("C_p0out",  64'(p0_out), 64'(32'h200 + c - 2));
      end
      if (databus_valid_0) begin
        if (beats < 8) check("C_wdata", 64'(databus_wdata_0), 64'(32'h100 + beats));
        else check("C_extra_beat", 64'(beats), 64'd7);
      end
      acct();
      if (c >= 10 && done) break;
    end
    check("C_done",  64'(done), 64'd1);
    check("C_beats", 64'(beats), 64'd8);

    // ---------------- run D: stall with ready low, FIFO fills ----------------
    start_run(64'h4000, 12'h400, 12'h001, 32'd8, 8'd7, 32'd0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      cyc(32'(32'h300 + c), 1'b0);
      if (c == 1) begin
        check("D_p1addr_c1", 64'(p1_addr), 64'h800);
        check("D_valid_c1",  64'(databus_valid_0), 64'd0);
      end
      if (c >= 2) begin
        check("D_valid", 64'(databus_valid_0), 64'd1);
        check("D_wdata_hold", 64'(databus_wdata_0), 64'd10);
      end
      if (c >= 3) check("D_no_issue_full", 64'(p1_en), 64'd0);
    end

    // ---------------- run E: restart mid-drain ----------------
    start_run(64'h5000, 12'h400, 12'h001, 32'd8, 8'd7, 32'd0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      cyc(32'd0, 1'b1);
      if (c == 1) begin
        check("E_flush_valid", 64'(databus_valid_0), 64'd0);
        check("E_bus_addr",    64'(databus_addr_0), 64'h5000);
        check("E_p1en",        64'(p1_en), 64'd1);
        check("E_p1addr",      64'(p1_addr), 64'h000);
      end
      check("E_valid", 64'(databus_valid_0), 64'((c >= 2) && (c <= 9)));
      if (c >= 2 && c <= 9) check("E_wdata", 64'(databus_wdata_0), 64'(32'h100 + c - 2));
      if (c == 10) check("E_done", 64'(done), 64'd1);
      acct();
    end

    // ---------------- run F: size 0 ----------------
    start_run(64'h6000, 12'h000, 12'h001, 32'd0, 8'd0, 32'd0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      cyc(32'd55, 1'b1);
      check("F_done",  64'(done), 64'd1);
      check("F_valid", 64'(databus_valid_0), 64'd0);
      check("F_p0en",  64'(p0_en), 64'd0);
      check("F_p1en",  64'(p1_en), 64'd0);
      acct();
    end

    // ---------------- run G: asynchronous reset mid-capture ----------------
    start_run(64'h7000, 12'h000, 12'h001, 32'd8, 8'd7, 32'd0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      cyc(32'(32'h400 + c), 1'b0);
      acct();
    end
    check("G_capturing", 64'(p0_en), 64'd1);
    check("G_busy",      64'(done), 64'd0);
    rst = 1'b1;
    #1;
    check("G_rst_done",  64'(done), 64'd1);
    check("G_rst_valid", 64'(databus_valid_0), 64'd0);
    check("G_rst_p0en",  64'(p0_en), 64'd0);
    check("G_rst_p1en",  64'(p1_en), 64'd0);
    check("G_rst_addr",  64'(databus_addr_0), 64'd0);
    check("G_rst_wdata", 64'(databus_wdata_0), 64'd0);
    check("G_rst_len",   64'(databus_len_0), 64'd0);
    @(negedge clk) rst = 1'b0;
    step();
    check("G_post_done",  64'(done), 64'd1);
    check("G_post_valid", 64'(databus_valid_0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
